tx_arp_reply: RTL and testbench

//  Consumes the ARP fields parsed by the receive ARP stage and, for a valid ARP request

---
 rtl/tx_arp_reply.sv | 199 +++++++++++++++++++
 tb/tb_tx_arp_reply.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arp_reply.sv
// ARP reply generator: answers ARP requests for LOCAL_IP with an 8-bit AXI-stream payload.
// Define TX_ARP_PAD_EN to zero-pad the payload to the 46-byte Ethernet minimum.
module tx_arp_reply #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000102,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8010A
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_rst,
  input  logic        arp_valid,
  input  logic [15:0] arp_opcode,
  input  logic [47:0] arp_srcMac,
  input  logic [31:0] arp_srcIP,
  input  logic [31:0] arp_destIP,
  output logic [47:0] tx_destMac,
  output logic [15:0] tx_ethType,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid
);

`ifdef TX_ARP_PAD_EN
  localparam int FRAME_LEN = 46;
`else
  localparam int FRAME_LEN = 28;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  // Bytes past the 28-byte image shift out as zero, which is the padding.
  function automatic logic [7:0] reply_byte(
    input logic [5:0]  idx,
    input logic [47:0] mac,
    input logic [31:0] ip
  );
    logic [223:0] img;
    logic [223:0] sh;
    img = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
           LOCAL_MAC, LOCAL_IP, mac, ip};
    sh = img << {idx, 3'b000};
    return sh[223:216];
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] cur_mac_q, cur_mac_d;
  logic [31:0] cur_ip_q, cur_ip_d;
  logic        pend_vld_q, pend_vld_d;
  logic [47:0] pend_mac_q, pend_mac_d;
  logic [31:0] pend_ip_q, pend_ip_d;
  logic [47:0] dest_mac_q, dest_mac_d;
  logic        busy_q, busy_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;

  logic        hs;
  logic        last_hs;
  logic        accept;
  logic [5:0]  nxt_cnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_mac_d  = cur_mac_q;
    cur_ip_d   = cur_ip_q;
    pend_vld_d = pend_vld_q;
    pend_mac_d = pend_mac_q;
    pend_ip_d  = pend_ip_q;
    dest_mac_d = dest_mac_q;
    busy_d     = busy_q;
    drop_d     = drop_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;

    hs      = tvalid_q & m_axis_tready;
    last_hs = hs & tlast_q;
    accept  = arp_valid & (arp_opcode == 16'h0001)
            & (arp_destIP == LOCAL_IP);
    nxt_cnt = cnt_q + 6'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_mac_d = arp_srcMac;
          cur_ip_d  = arp_srcIP;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        dest_mac_d = cur_mac_q;
        cnt_d      = 6'd0;
        tdata_d    = reply_byte(6'd0, cur_mac_q, cur_ip_q);
        tuser_d    = 1'b1;
        tlast_d    = 1'b0;
        tvalid_d   = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (hs) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 8'h00;
            if (pend_vld_q) begin
              cur_mac_d  = pend_mac_q;
              cur_ip_d   = pend_ip_q;
              pend_vld_d = 1'b0;
              state_d    = LOAD;
            end else if (accept) begin
              cur_mac_d = arp_srcMac;
              cur_ip_d  = arp_srcIP;
              state_d   = LOAD;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            cnt_d   = nxt_cnt;
            tdata_d = reply_byte(nxt_cnt, cur_mac_q, cur_ip_q);
            tuser_d = 1'b0;
            tlast_d = (nxt_cnt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot drained by this cycle's last byte can take the new request.
    if (accept && (state_q != IDLE)
        && !(last_hs && !pend_vld_q)) begin
      if (!pend_vld_q || last_hs) begin
        pend_vld_d = 1'b1;
        pend_mac_d = arp_srcMac;
        pend_ip_d  = arp_srcIP;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      cur_mac_q  <= 48'd0;
      cur_ip_q   <= 32'd0;
      pend_vld_q <= 1'b0;
      pend_mac_q <= 48'd0;
      pend_ip_q  <= 32'd0;
      dest_mac_q <= 48'd0;
      busy_q     <= 1'b0;
      drop_q     <= 8'd0;
      tdata_q    <= 8'd0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_mac_q  <= cur_mac_d;
      cur_ip_q   <= cur_ip_d;
      pend_vld_q <= pend_vld_d;
      pend_mac_q <= pend_mac_d;
      pend_ip_q  <= pend_ip_d;
      dest_mac_q <= dest_mac_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign tx_destMac    = dest_mac_q;
  assign tx_ethType    = 16'h0806;
  assign busy          = busy_q;
  assign drop_cnt      = drop_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_tx_arp_reply.sv
// Bench for tx_arp_reply: directed steps plus random requests checked
// against a frame-level reference model.
module tb_tx_arp_reply;

  localparam logic [47:0] LMAC = 48'h000A35000102;
  localparam logic [31:0] LIP  = 32'hC0A8010A;
`ifdef TX_ARP_PAD_EN
  localparam int LEN = 46;
`else
  localparam int LEN = 28;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_valid = 1'b0;
  logic [15:0] arp_opcode = 16'd0;
  logic [47:0] arp_srcMac = 48'd0;
  logic [31:0] arp_srcIP = 32'd0;
  logic [31:0] arp_destIP = 32'd0;
  logic [47:0] tx_destMac;
  logic [15:0] tx_ethType;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tready = 1'b1;
  logic        tuser;
  logic        tvalid;

  always #5 clk = ~clk;

  tx_arp_reply dut (
    .s_axis_aclk  (clk),
    .s_axis_rst   (rst),
    .arp_valid    (arp_valid),
    .arp_opcode   (arp_opcode),
    .arp_srcMac   (arp_srcMac),
    .arp_srcIP    (arp_srcIP),
    .arp_destIP   (arp_destIP),
    .tx_destMac   (tx_destMac),
    .tx_ethType   (tx_ethType),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .m_axis_tdata (tdata),
    .m_axis_tlast (tlast),
    .m_axis_tready(tready),
    .m_axis_tuser (tuser),
    .m_axis_tvalid(tvalid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
  } req_t;

  req_t q[$];
  int   bidx = 0;
  int   outstanding = 0;
  int   frames_done = 0;
  int   exp_drop = 0;
  logic stalled = 1'b0;
  logic [7:0] p_data;
  logic p_user, p_last;

  function automatic logic [7:0] exp_byte(input int i, input req_t r);
    case (i)
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h08;
      3: return 8'h00;
      4: return 8'h06;
      5: return 8'h04;
      6: return 8'h00;
      7: return 8'h02;
      default: ;
    endcase
    if (i < 14) return 8'(LMAC >> (8 * (13 - i)));
    if (i < 18) return 8'(LIP >> (8 * (17 - i)));
    if (i < 24) return 8'(r.mac >> (8 * (23 - i)));
    if (i < 28) return 8'(r.ip >> (8 * (27 - i)));
    return 8'h00;
  endfunction

  // Frame-level model: at most one frame in service plus one waiting.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      bidx = 0;
      outstanding = 0;
      exp_drop = 0;
      stalled = 1'b0;
    end else begin
      chk("busy", busy, outstanding != 0);
      if (outstanding == 0) chk("idle_tvalid", tvalid, 0);
      if (stalled) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, p_data);
        chk("hold_user", tuser, p_user);
        chk("hold_last", tlast, p_last);
      end else if (bidx > 0) begin
        chk("mid_tvalid", tvalid, 1);
      end
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          chk("stray_byte", tvalid, 0);
        end else begin
          chk("dest_mac", tx_destMac, q[0].mac);
          chk("tdata", tdata, exp_byte(bidx, q[0]));
          chk("tuser", tuser, bidx == 0);
          chk("tlast", tlast, bidx == LEN - 1);
          bidx++;
          if (bidx == LEN) begin
            void'(q.pop_front());
            bidx = 0;
            outstanding--;
            frames_done++;
          end
        end
      end
      if (arp_valid && arp_opcode == 16'h0001 && arp_destIP == LIP) begin
        if (outstanding < 2) begin
          q.push_back('{arp_srcMac, arp_srcIP});
          outstanding++;
        end else if (exp_drop < 255) begin
          exp_drop++;
        end
      end
      stalled = tvalid && !tready;
      p_data = tdata;
      p_user = tuser;
      p_last = tlast;
    end
  end

  int rdy_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: tready = 1'b1;
      1: tready = !tready;
      2: tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  endtask

  task automatic req(input logic [15:0] op, input logic [47:0] mac,
                     input logic [31:0] ip, input logic [31:0] dst);
    arp_valid  = 1'b1;
    arp_opcode = op;
    arp_srcMac = mac;
    arp_srcIP  = ip;
    arp_destIP = dst;
    step();
    arp_valid = 1'b0;
  endtask

  task automatic run_frames(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && outstanding == 0) break;
      step();
    end
    chk("drain_busy", busy, 0);
    chk("drain_q", q.size(), 0);
    step();
  endtask

  task automatic wait_sof();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid && tuser) break;
    end
    chk("sof_seen", tvalid && tuser, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int f0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_dmac", tx_destMac, 0);
    chk("ethtype", tx_ethType, 16'h0806);
    step();
    rst = 1'b0;
    step();

    // 1: basic reply and latency
    req(16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
    @(negedge clk);
    chk("t1_lat1", tvalid, 0);
    step();
    @(negedge clk);
    chk("t1_lat2", tvalid, 1);
    chk("t1_sof", tuser, 1);
    chk("t1_dmac", tx_destMac, 48'h112233445566);
    run_frames(200);
    chk("t1_frames", frames_done, 1);

    // 2: foreign IP and reply opcode ignored
    req(16'h0001, 48'h0102030405AA, 32'hC0A80105, 32'hC0A80199);
    req(16'h0002, 48'h0102030405BB, 32'hC0A80105, LIP);
    repeat (4) step();
    @(negedge clk);
    chk("t2_tvalid", tvalid, 0);
    chk("t2_busy", busy, 0);
    chk("t2_drop", drop_cnt, 0);
    step();

    // 3: tready toggling
    rdy_mode = 1;
    req(16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
    run_frames(400);
    rdy_mode = 0;
    chk("t3_frames", frames_done, 2);

    // 4: three back-to-back requests
    f0 = frames_done;
    req(16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
    req(16'h0001, 48'h112233445577, 32'hC0A80105, LIP);
    req(16'h0001, 48'h112233445588, 32'hC0A80105, LIP);
    run_frames(400);
    chk("t4_frames", frames_done - f0, 2);
    chk("t4_drop", drop_cnt, 1);

    // 5: reset at byte 10
    req(16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
    wait_sof();
    repeat (10) step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_byte10", tdata, 8'h35);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tvalid", tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tlast", tlast, 0);
    chk("t5_drop", drop_cnt, 0);
    step();
    req(16'h0001, 48'hA1A2A3A4A5A6, 32'hC0A80177, LIP);
    run_frames(200);

    // 6: request coincident with last handshake
    req(16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
    wait_sof();
    repeat (LEN - 1) step();
    arp_valid  = 1'b1;
    arp_opcode = 16'h0001;
    arp_srcMac = 48'hCAFEBABE0099;
    arp_srcIP  = 32'hC0A80142;
    arp_destIP = LIP;
    @(negedge clk);
    chk("t6_align", tlast, 1);
    step();
    arp_valid = 1'b0;
    @(negedge clk);
    chk("t6_load_tv", tvalid, 0);
    chk("t6_load_busy", busy, 1);
    step();
    @(negedge clk);
    chk("t6_sof", tvalid && tuser, 1);
    chk("t6_dmac", tx_destMac, 48'hCAFEBABE0099);
    run_frames(200);
    chk("t6_drop", drop_cnt, 0);

    // drop counter saturation while downstream is stalled
    rdy_mode = 3;
    step();
    for (int i = 0; i < 300; i++)
      req(16'h0001, {16'h5500, 32'(i)}, 32'(i), LIP);
    @(negedge clk);
    chk("sat_drop", drop_cnt, 8'd255);
    chk("sat_model", drop_cnt, exp_drop);
    rdy_mode = 0;
    run_frames(400);
    chk("sat_hold", drop_cnt, 8'd255);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("sat_clear", drop_cnt, 0);
    step();

    // random requests against the model
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] op;
      logic [31:0] dst;
      repeat ($urandom_range(0, 3)) step();
      op  = ($urandom_range(0, 4) == 0) ? 16'h0002 : 16'h0001;
      dst = ($urandom_range(0, 5) == 0) ? $urandom : LIP;
      req(op, {16'($urandom), 32'($urandom)}, $urandom, dst);
    end
    run_frames(5000);
    chk("rnd_drop", drop_cnt, 8'(exp_drop));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
